// File: rtl/enc_link_decoder.sv
// Receive-end decoder for the 3-line encoded link: captures codes into a small
// FWFT FIFO and presents the head word as a restored one-hot byte.
module enc_link_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       dec_a2value,
  input  logic                       dec_a1value,
  input  logic                       dec_a0value,
  input  logic                       EN_dec,
  output logic                       RDY_dec,
  output logic [7:0]                 dec_y_value,
  output logic [2:0]                 dec_code,
  output logic                       RDY_dec_out,
  input  logic                       EN_dec_out,
  output logic [$clog2(DEPTH):0]     dec_level,
  output logic [CNT_W-1:0]           dec_count,
  output logic                       dec_overflow,
  input  logic                       EN_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [2:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic [2:0] w_code;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;

  assign w_code  = {dec_a2value, dec_a1value, dec_a0value};
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  // Full blocks the push outright, so a pop at full never passes a word through.
  assign w_push  = EN_dec && !w_full;
  assign w_pop   = EN_dec_out && !w_empty;
  assign w_drop  = EN_dec && w_full;

  // NOTE: storage is deliberately left out of reset; the level/pointers decide
  // what is valid, and a reset-free array maps onto plain RAM/regfile cells.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_code;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Clear and push on the same edge leave the count at 1; a drop beats clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (EN_clr)      r_count <= w_push ? CNT_W'(1) : '0;
      else if (w_push) r_count <= r_count + CNT_W'(1);

      if (w_drop)      r_overflow <= 1'b1;
      else if (EN_clr) r_overflow <= 1'b0;
    end
  end

  assign RDY_dec      = !w_full;
  assign RDY_dec_out  = !w_empty;
  assign dec_code     = w_empty ? 3'd0 : r_mem[r_rd_ptr];
  assign dec_y_value  = w_empty ? 8'd0 : (8'd1 << dec_code);
  assign dec_level    = r_level;
  assign dec_count    = r_count;
  assign dec_overflow = r_overflow;

endmodule

// File: tb/tb_enc_link_decoder.sv
// Directed bench for enc_link_decoder: a queue scoreboard of accepted codes is
// compared against the head word, plus a model of level, count and overflow.
module tb_enc_link_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             dec_a2value = 1'b0, dec_a1value = 1'b0, dec_a0value = 1'b0;
  logic             EN_dec = 1'b0, EN_dec_out = 1'b0, EN_clr = 1'b0;
  logic             RDY_dec, RDY_dec_out, dec_overflow;
  logic [7:0]       dec_y_value;
  logic [2:0]       dec_code;
  logic [2:0]       dec_level;
  logic [CNT_W-1:0] dec_count;

  enc_link_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .dec_a2value(dec_a2value), .dec_a1value(dec_a1value), .dec_a0value(dec_a0value),
    .EN_dec(EN_dec), .RDY_dec(RDY_dec),
    .dec_y_value(dec_y_value), .dec_code(dec_code), .RDY_dec_out(RDY_dec_out),
    .EN_dec_out(EN_dec_out), .dec_level(dec_level), .dec_count(dec_count),
    .dec_overflow(dec_overflow), .EN_clr(EN_clr)
  );

  always #5 CLK = ~CLK;

  int               total = 0;
  int               bad = 0;
  logic [2:0]       sb_q[$];
  logic [CNT_W-1:0] m_count = '0;
  logic             m_ov = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},     32'(RDY_dec), 32'd1);
    check({tag, "_rdy_out"}, 32'(RDY_dec_out), 32'd0);
    check({tag, "_y"},       32'(dec_y_value), 32'd0);
    check({tag, "_code"},    32'(dec_code), 32'd0);
    check({tag, "_level"},   32'(dec_level), 32'd0);
    check({tag, "_count"},   32'(dec_count), 32'd0);
    check({tag, "_ov"},      32'(dec_overflow), 32'd0);
  endtask

  // One clock: drive inputs, check head/ready mid-cycle, update model, check state.
  task automatic cyc(input logic en, input logic [2:0] code, input logic pop, input logic clr);
    logic push_ok, pop_ok, drop;
    EN_dec = en;
    {dec_a2value, dec_a1value, dec_a0value} = code;
    EN_dec_out = pop;
    EN_clr = clr;
    @(negedge CLK);
    check("rdy", 32'(RDY_dec), 32'(sb_q.size() != DEPTH));
    check("rdy_out", 32'(RDY_dec_out), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      check("head_code", 32'(dec_code), 32'(sb_q[0]));
      check("head_y", 32'(dec_y_value), 32'(8'd1 << sb_q[0]));
    end else begin
      check("empty_y", 32'(dec_y_value), 32'd0);
    end
    @(posedge CLK);
    push_ok = en && (sb_q.size() != DEPTH);
    pop_ok  = pop && (sb_q.size() != 0);
    drop    = en && !push_ok;
    if (pop_ok)  void'(sb_q.pop_front());
    if (push_ok) sb_q.push_back(code);
    if (clr)          m_count = push_ok ? CNT_W'(1) : '0;
    else if (push_ok) m_count = m_count + CNT_W'(1);
    if (drop)     m_ov = 1'b1;
    else if (clr) m_ov = 1'b0;
    #1;
    EN_dec = 1'b0; EN_dec_out = 1'b0; EN_clr = 1'b0;
    check("level", 32'(dec_level), 32'(sb_q.size()));
    check("count", 32'(dec_count), 32'(m_count));
    check("overflow", 32'(dec_overflow), 32'(m_ov));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check_reset_outputs("reset");
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Codes 0..7 with continuous pop: one-hot 0x01..0x80 in order
    for (int k = 0; k < 8; k++) cyc(1'b1, 3'(k), 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);
    check("count_after_8", 32'(dec_count), 32'd8);
    check("level_drained", 32'(dec_level), 32'd0);

    // Fill to full, drop a fifth code, drain
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    cyc(1'b1, 3'd5, 1'b0, 1'b0);
    cyc(1'b1, 3'd3, 1'b0, 1'b0);
    cyc(1'b1, 3'd6, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 1'b0, 1'b0);
    check("full_level", 32'(dec_level), 32'd4);
    check("full_rdy", 32'(RDY_dec), 32'd0);
    cyc(1'b1, 3'd7, 1'b0, 1'b0);
    check("drop_ov", 32'(dec_overflow), 32'd1);
    check("drop_count", 32'(dec_count), 32'd4);
    check("drop_head_y", 32'(dec_y_value), 32'h20);
    for (int k = 0; k < 4; k++) cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Simultaneous push and pop at level 2
    cyc(1'b1, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 1'b1, 1'b0);
    check("pushpop_level", 32'(dec_level), 32'd2);
    check("pushpop_head", 32'(dec_y_value), 32'h04);
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // 260 accepted words with continuous pop: counter wraps to 4
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 260; k++) cyc(1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
    check("count_wrap", 32'(dec_count), 32'd4);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    check("clr_alone", 32'(dec_count), 32'd0);
    cyc(1'b1, 3'd3, 1'b0, 1'b1);
    check("clr_push", 32'(dec_count), 32'd1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 3'(k + 4), 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 1'b0, 1'b1);
    check("clr_drop_ov", 32'(dec_overflow), 32'd1);
    check("clr_drop_level", 32'(dec_level), 32'd4);
    for (int k = 0; k < 4; k++) cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-operation flushes the FIFO
    for (int k = 0; k < 3; k++) cyc(1'b1, 3'(k + 5), 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb_q.delete();
    m_count = '0;
    m_ov = 1'b0;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    cyc(1'b1, 3'd2, 1'b0, 1'b0);
    check("post_reset_y", 32'(dec_y_value), 32'h04);
    check("post_reset_level", 32'(dec_level), 32'd1);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Pop while empty is ignored
    for (int k = 0; k < 10; k++) cyc(1'b0, 3'd0, 1'b1, 1'b0);
    check("empty_pop_level", 32'(dec_level), 32'd0);
    check("empty_pop_y", 32'(dec_y_value), 32'd0);
    check("empty_pop_count", 32'(dec_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
